// File: rtl/mtr_drv_pkg.sv
// rtl/mtr_drv_pkg.sv - shared motor-driver types and constants
package mtr_drv_pkg;

    localparam int DT_W_DEF  = 6;
    localparam int MTR_PWM_W = 11;

    // Bit positions of the one-hot state vector; outputs tap these flops directly.
    localparam int ST_OFF_BIT    = 0;
    localparam int ST_DLY_HI_BIT = 1;
    localparam int ST_HI_ON_BIT  = 2;
    localparam int ST_DLY_LO_BIT = 3;
    localparam int ST_LO_ON_BIT  = 4;

    typedef enum logic [4:0] {
        ST_OFF    = 5'b00001,
        ST_DLY_HI = 5'b00010,
        ST_HI_ON  = 5'b00100,
        ST_DLY_LO = 5'b01000,
        ST_LO_ON  = 5'b10000
    } dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - complementary half-bridge drive with dead time; optional PWM_DEADTIME_FAULT_EN
module pwm_deadtime
    import mtr_drv_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
`ifdef PWM_DEADTIME_FAULT_EN
    input  logic            ovr_curr,
    output logic            fault,
`endif
    output logic            hi_drv,
    output logic            lo_drv,
    output logic            dt_active
);

    dt_state_t       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            trip;

`ifdef PWM_DEADTIME_FAULT_EN
    logic fault_q, fault_d;

    // A new overcurrent wins over a simultaneous disable so the trip is never lost.
    always_comb begin
        fault_d = ovr_curr | (fault_q & en);
        trip    = ovr_curr | fault_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    assign trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en || trip) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = pwm_in ? ST_DLY_HI : ST_DLY_LO;
                    cnt_d   = dead_time;
                end
                // A reversal inside a dead interval restarts it toward the other side.
                ST_DLY_HI: begin
                    if (!pwm_in) begin
                        state_d = ST_DLY_LO;
                        cnt_d   = dead_time;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HI_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                ST_DLY_LO: begin
                    if (pwm_in) begin
                        state_d = ST_DLY_HI;
                        cnt_d   = dead_time;
                    end else if (cnt_q == '0) begin
                        state_d = ST_LO_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                ST_HI_ON: begin
                    if (!pwm_in) begin
                        state_d = ST_DLY_LO;
                        cnt_d   = dead_time;
                    end
                end
                ST_LO_ON: begin
                    if (pwm_in) begin
                        state_d = ST_DLY_HI;
                        cnt_d   = dead_time;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign hi_drv    = state_q[ST_HI_ON_BIT];
    assign lo_drv    = state_q[ST_LO_ON_BIT];
    assign dt_active = state_q[ST_DLY_HI_BIT] | state_q[ST_DLY_LO_BIT];

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb/tb_pwm_deadtime.sv - scoreboard bench for pwm_deadtime
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pwm_in = 1'b0;
    logic [5:0] dead_time = '0;
    logic       hi_drv, lo_drv, dt_active;
`ifdef PWM_DEADTIME_FAULT_EN
    logic       ovr_curr = 1'b0;
    logic       fault;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       pwm;
        logic [5:0] dt;
        logic       ovr;
    } stim_t;

    typedef struct {
        logic hi;
        logic lo;
        logic dta;
        logic flt;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];

    always #10 clk = ~clk;

    pwm_deadtime #(.DT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
`ifdef PWM_DEADTIME_FAULT_EN
        .ovr_curr  (ovr_curr),
        .fault     (fault),
`endif
        .hi_drv    (hi_drv),
        .lo_drv    (lo_drv),
        .dt_active (dt_active)
    );

    // One stimulus cycle plus the outputs the design must show after the next edge.
    task automatic push(input logic r, input logic e, input logic p, input logic [5:0] d,
                        input logic h, input logic l, input logic a);
        stim_q.push_back(stim_t'{r, e, p, d, 1'b0});
        exp_q.push_back(exp_t'{h, l, a, 1'b0});
    endtask

    task automatic push_n(input int n, input logic e, input logic p, input logic [5:0] d,
                          input logic h, input logic l, input logic a);
        for (int i = 0; i < n; i++) push(1'b1, e, p, d, h, l, a);
    endtask

    task automatic test_reset;
        stim_t s;
        exp_t  x;
        int    cyc = 0;
        push(1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
        push_n(4, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 1'b1);
        push_n(3, 1'b1, 1'b1, 6'd3, 1'b1, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            rst_n = s.rst_n; en = s.en; pwm_in = s.pwm; dead_time = s.dt;
            @(posedge clk); #1;
            checks++;
            if ({hi_drv, lo_drv, dt_active} !== {x.hi, x.lo, x.dta}) begin
                errors++;
                $display("FAIL reset cyc=%0d hi/lo/dt got=%b%b%b exp=%b%b%b",
                         cyc, hi_drv, lo_drv, dt_active, x.hi, x.lo, x.dta);
            end
            cyc++;
        end
    endtask

    task automatic test_basic_deadtime;
        stim_t s;
        exp_t  x;
        int    cyc = 0;
        push_n(5, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0, 1'b1);
        push_n(3, 1'b1, 1'b0, 6'd4, 1'b0, 1'b1, 1'b0);
        push_n(1, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0, 1'b1);
        // dead_time change mid-interval must not stretch or shorten it
        push_n(4, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b1);
        push_n(3, 1'b1, 1'b1, 6'd9, 1'b1, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            rst_n = s.rst_n; en = s.en; pwm_in = s.pwm; dead_time = s.dt;
            @(posedge clk); #1;
            checks++;
            if ({hi_drv, lo_drv, dt_active} !== {x.hi, x.lo, x.dta}) begin
                errors++;
                $display("FAIL basic cyc=%0d hi/lo/dt got=%b%b%b exp=%b%b%b",
                         cyc, hi_drv, lo_drv, dt_active, x.hi, x.lo, x.dta);
            end
            cyc++;
        end
    endtask

    task automatic test_zero_deadtime;
        stim_t s;
        exp_t  x;
        int    cyc = 0;
        for (int t = 0; t < 4; t++) begin
            logic lvl;
            lvl = (t % 2 == 1);
            push_n(1, 1'b1, lvl, 6'd0, 1'b0, 1'b0, 1'b1);
            push_n(7, 1'b1, lvl, 6'd0, lvl, ~lvl, 1'b0);
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            rst_n = s.rst_n; en = s.en; pwm_in = s.pwm; dead_time = s.dt;
            @(posedge clk); #1;
            checks++;
            if ({hi_drv, lo_drv, dt_active} !== {x.hi, x.lo, x.dta}) begin
                errors++;
                $display("FAIL zero_dt cyc=%0d hi/lo/dt got=%b%b%b exp=%b%b%b",
                         cyc, hi_drv, lo_drv, dt_active, x.hi, x.lo, x.dta);
            end
            checks++;
            if ((hi_drv & lo_drv) !== 1'b0) begin
                errors++;
                $display("FAIL zero_dt_overlap cyc=%0d hi&lo got=%b exp=0", cyc, hi_drv & lo_drv);
            end
            cyc++;
        end
    endtask

    task automatic test_short_pulse;
        stim_t s;
        exp_t  x;
        int    cyc = 0;
        push_n(11, 1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 1'b1);
        push_n(3,  1'b1, 1'b0, 6'd10, 1'b0, 1'b1, 1'b0);
        push_n(3,  1'b1, 1'b1, 6'd10, 1'b0, 1'b0, 1'b1);
        push_n(11, 1'b1, 1'b0, 6'd10, 1'b0, 1'b0, 1'b1);
        push_n(3,  1'b1, 1'b0, 6'd10, 1'b0, 1'b1, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            rst_n = s.rst_n; en = s.en; pwm_in = s.pwm; dead_time = s.dt;
            @(posedge clk); #1;
            checks++;
            if ({hi_drv, lo_drv, dt_active} !== {x.hi, x.lo, x.dta}) begin
                errors++;
                $display("FAIL short_pulse cyc=%0d hi/lo/dt got=%b%b%b exp=%b%b%b",
                         cyc, hi_drv, lo_drv, dt_active, x.hi, x.lo, x.dta);
            end
            cyc++;
        end
    endtask

    task automatic test_disable;
        stim_t s;
        exp_t  x;
        int    cyc = 0;
        push_n(2, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b1);
        push_n(3, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        push_n(6, 1'b1, 1'b0, 6'd5, 1'b0, 1'b0, 1'b1);
        push_n(3, 1'b1, 1'b0, 6'd5, 1'b0, 1'b1, 1'b0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            rst_n = s.rst_n; en = s.en; pwm_in = s.pwm; dead_time = s.dt;
            @(posedge clk); #1;
            checks++;
            if ({hi_drv, lo_drv, dt_active} !== {x.hi, x.lo, x.dta}) begin
                errors++;
                $display("FAIL disable cyc=%0d hi/lo/dt got=%b%b%b exp=%b%b%b",
                         cyc, hi_drv, lo_drv, dt_active, x.hi, x.lo, x.dta);
            end
            cyc++;
        end
    endtask

`ifdef PWM_DEADTIME_FAULT_EN
    task automatic test_fault;
        stim_t s;
        exp_t  x;
        int    cyc = 0;
        for (int i = 0; i < 3; i++) begin
            stim_q.push_back(stim_t'{1'b1, 1'b1, 1'b1, 6'd2, 1'b0});
            exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b1, 1'b0});
        end
        for (int i = 0; i < 2; i++) begin
            stim_q.push_back(stim_t'{1'b1, 1'b1, 1'b1, 6'd2, 1'b0});
            exp_q.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0});
        end
        stim_q.push_back(stim_t'{1'b1, 1'b1, 1'b1, 6'd2, 1'b1});
        exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b1});
        for (int i = 0; i < 50; i++) begin
            stim_q.push_back(stim_t'{1'b1, 1'b1, 1'b1, 6'd2, 1'b0});
            exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b1});
        end
        stim_q.push_back(stim_t'{1'b1, 1'b0, 1'b1, 6'd2, 1'b0});
        exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            stim_q.push_back(stim_t'{1'b1, 1'b1, 1'b1, 6'd2, 1'b0});
            exp_q.push_back(exp_t'{1'b0, 1'b0, 1'b1, 1'b0});
        end
        stim_q.push_back(stim_t'{1'b1, 1'b1, 1'b1, 6'd2, 1'b0});
        exp_q.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0});
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            x = exp_q.pop_front();
            rst_n = s.rst_n; en = s.en; pwm_in = s.pwm; dead_time = s.dt; ovr_curr = s.ovr;
            @(posedge clk); #1;
            checks++;
            if ({hi_drv, lo_drv, dt_active, fault} !== {x.hi, x.lo, x.dta, x.flt}) begin
                errors++;
                $display("FAIL fault cyc=%0d hi/lo/dt/flt got=%b%b%b%b exp=%b%b%b%b",
                         cyc, hi_drv, lo_drv, dt_active, fault, x.hi, x.lo, x.dta, x.flt);
            end
            cyc++;
        end
        ovr_curr = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_deadtime();
        test_zero_deadtime();
        test_short_pulse();
        test_disable();
`ifdef PWM_DEADTIME_FAULT_EN
        test_fault();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
